// File: rtl/mcp_lcseq_pkg.sv
// Shared definitions for the microprogram location-counter sequencer.
// Latency: n/a (types, field positions and op encodings only).
// Backpressure: n/a.
package mcp_lcseq_pkg;

    // Microaddress and microword widths
    localparam int LC_W   = 11;
    localparam int MO_W   = 22;
    localparam int COND_W = 16;

    // Microword field positions
    localparam int OP_HI     = 21;
    localparam int OP_LO     = 18;
    localparam int INTOK_BIT = 17;
    localparam int CSEL_HI   = 14;
    localparam int CSEL_LO   = 11;
    localparam int TGT_HI    = 10;
    localparam int TGT_LO    = 0;

    // Sequencer operations; codes 7..15 are not listed and fall through as NEXT
    typedef enum logic [3:0] {
        OP_NEXT = 4'd0,
        OP_JUMP = 4'd1,
        OP_CALL = 4'd2,
        OP_RET  = 4'd3,
        OP_BRT  = 4'd4,
        OP_BRF  = 4'd5,
        OP_WAIT = 4'd6
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Next sequential microaddress; 11-bit arithmetic wraps 7FF -> 000
    function automatic logic [LC_W-1:0] lc_inc(input logic [LC_W-1:0] lc);
        return lc + 1'b1;
    endfunction

endpackage

// File: rtl/mcp_lcseq_stack.sv
// LIFO return-address stack for the sequencer (push/pop, full/empty, top-of-stack).
// Latency: push/pop take effect on the next rising edge; tos_dat is combinational from the pointer.
// Backpressure: push while full and pop while empty are dropped; the caller flags the error.
module mcp_lcstack
    import mcp_lcseq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            pin_clk,
    input  logic            pin_rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [LC_W-1:0] push_dat,
    output logic [LC_W-1:0] tos_dat,
    output logic            full,
    output logic            empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ptr counts valid entries, 0..DEPTH; entry ptr-1 is the top
    logic [PTR_W-1:0] ptr;
    logic [LC_W-1:0]  mem [0:(1 << IDX_W)-1];
    logic             do_push;
    logic             do_pop;

    assign full    = (ptr == PTR_W'(DEPTH));
    assign empty   = (ptr == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !push && !empty;
    assign tos_dat = mem[IDX_W'(ptr - 1'b1)];

    // Stack pointer: the only stack state that needs reset
    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            ptr <= '0;
        end else if (do_push) begin
            ptr <= ptr + 1'b1;
        end else if (do_pop) begin
            ptr <= ptr - 1'b1;
        end
    end

    // Entry storage; contents are never read while the pointer is 0
    always_ff @(posedge pin_clk) begin
        if (do_push) begin
            mem[IDX_W'(ptr)] <= push_dat;
        end
    end

endmodule

// File: rtl/mcp_lcseq.sv
// Microprogram location-counter sequencer: FETCH/EXEC/WAIT FSM driving MicROM address.
// Latency: 2 clocks per microinstruction (FETCH then EXEC); pin_lc updates on the EXEC edge.
// Backpressure: WAIT op stalls in WAIT state until pin_rdy=1; no other flow control.
module mcp_lcseq
    import mcp_lcseq_pkg::*;
#(
    parameter logic [10:0] START_ADDR  = 11'h000,
    parameter logic [10:0] IRQ_VECTOR  = 11'h7F0,
    parameter int          STACK_DEPTH = 4
) (
    input  logic              pin_clk,
    input  logic              pin_rst_n,
    input  logic [MO_W-1:0]   pin_mo,
    input  logic [COND_W-1:0] pin_cond,
    input  logic              pin_rdy,
    input  logic              pin_irq,
    output logic [LC_W-1:0]   pin_lc,
    output logic              pin_mv,
    output logic              pin_iack,
    output logic              pin_err
);

    state_e          state;
    op_e             op;
    logic [LC_W-1:0] target;
    logic [3:0]      csel;
    logic            intok;
    logic            cond_bit;
    logic [LC_W-1:0] lc_nxt;
    logic            irq_take;
    logic            push_req;
    logic            pop_req;
    logic [LC_W-1:0] tos_dat;
    logic            stk_full;
    logic            stk_empty;
    logic            unused_mo_bits;

    // Microword field decode
    assign op             = op_e'(pin_mo[OP_HI:OP_LO]);
    assign intok          = pin_mo[INTOK_BIT];
    assign csel           = pin_mo[CSEL_HI:CSEL_LO];
    assign target         = pin_mo[TGT_HI:TGT_LO];
    assign unused_mo_bits = ^pin_mo[INTOK_BIT-1:CSEL_HI+1];
    assign cond_bit       = pin_cond[csel];
    assign lc_nxt         = lc_inc(pin_lc);
    assign pin_mv         = (state == ST_EXEC);

    // Stack requests only fire in EXEC; an interrupt is taken only on a plain NEXT word
    always_comb begin
        irq_take = 1'b0;
        push_req = 1'b0;
        pop_req  = 1'b0;
        if (state == ST_EXEC) begin
            irq_take = (op == OP_NEXT) && intok && pin_irq;
            push_req = (op == OP_CALL) || irq_take;
            pop_req  = (op == OP_RET);
        end
    end

    mcp_lcstack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .pin_clk   (pin_clk),
        .pin_rst_n (pin_rst_n),
        .push      (push_req),
        .pop       (pop_req),
        .push_dat  (lc_nxt),
        .tos_dat   (tos_dat),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Sequencer FSM with registered location counter, iack pulse and sticky error
    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            state    <= ST_FETCH;
            pin_lc   <= START_ADDR;
            pin_iack <= 1'b0;
            pin_err  <= 1'b0;
        end else begin
            pin_iack <= 1'b0;
            case (state)
                ST_FETCH: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    state <= ST_FETCH;
                    case (op)
                        OP_NEXT: begin
                            if (irq_take) begin
                                pin_lc   <= IRQ_VECTOR;
                                pin_iack <= 1'b1;
                                if (stk_full) pin_err <= 1'b1;
                            end else begin
                                pin_lc <= lc_nxt;
                            end
                        end
                        OP_JUMP: pin_lc <= target;
                        OP_CALL: begin
                            pin_lc <= target;
                            if (stk_full) pin_err <= 1'b1;
                        end
                        OP_RET: begin
                            // Underflow restarts the microprogram from the reset address
                            if (stk_empty) begin
                                pin_lc  <= START_ADDR;
                                pin_err <= 1'b1;
                            end else begin
                                pin_lc <= tos_dat;
                            end
                        end
                        OP_BRT:  pin_lc <= cond_bit ? target : lc_nxt;
                        OP_BRF:  pin_lc <= cond_bit ? lc_nxt : target;
                        OP_WAIT: begin
                            if (pin_rdy) pin_lc <= lc_nxt;
                            else         state  <= ST_WAIT;
                        end
                        default: pin_lc <= lc_nxt;
                    endcase
                end
                ST_WAIT: begin
                    if (pin_rdy) begin
                        pin_lc <= lc_nxt;
                        state  <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
